// File: rtl/alu_bist_checker.sv
// alu_bist_checker
//   Self-test driver/checker for alu_4bit. On start it walks every {op,a,b}
//   vector into the ALU (b in the LSBs), compares result/zero against a
//   golden model and counts mismatching vectors in a saturating counter.
//   Each vector takes two cycles: DRIVE registers the operands, CHECK samples
//   the combinational ALU response.
//
// Parameters
//   WIDTH  operand/result width (vector space 2^(2*WIDTH+2))
//   ERR_W  error counter width, saturates at all-ones
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   1-cycle pulse, begins a sweep from IDLE or DONE
//   a_o/b_o   out  operands to ALU
//   op_o      out  opcode to ALU
//   result_i  in   ALU result
//   zero_i    in   ALU zero flag
//   busy      out  sweep in progress
//   done      out  sweep finished, held until start or rst
//   pass      out  done and no mismatches
//   err_cnt   out  mismatching vector count, saturating
//
// Optional build macro ALU_BIST_FAIL_CAPTURE_EN adds fail_vld/fail_vec/
// fail_res, which record the first mismatching vector of a sweep and the
// result the ALU returned for it.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | after reset, waiting for start
// DRIVE | register current vector onto a_o/b_o/op_o
// CHECK | compare ALU response, advance vector or finish
// DONE  | sweep complete, status held until next start

module alu_bist_checker #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic [1:0]           op_o,
  input  logic [WIDTH-1:0]     result_i,
  input  logic                 zero_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_cnt
`ifdef ALU_BIST_FAIL_CAPTURE_EN
  ,
  output logic                 fail_vld,
  output logic [2*WIDTH+1:0]   fail_vec,
  output logic [WIDTH-1:0]     fail_res
`endif
);

  localparam int VW = 2*WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   vec;
  logic            clr, drv, chk;
  logic            last_vec;
  logic [WIDTH-1:0] exp_res;
  logic            exp_zero;
  logic            mismatch;

  assign last_vec = &vec;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    drv     = 1'b0;
    chk     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        drv     = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        chk     = 1'b1;
        state_d = last_vec ? DONE : DRIVE;
      end
      DONE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == DRIVE) || (state_q == CHECK);
  assign done = (state_q == DONE);
  assign pass = done && (err_cnt == '0);

  // Golden model evaluated on the registered operands; carry/borrow dropped.
  always_comb begin
    exp_res = '0;
    case (op_o)
      2'b00:   exp_res = a_o + b_o;
      2'b01:   exp_res = a_o - b_o;
      2'b10:   exp_res = a_o & b_o;
      default: exp_res = a_o | b_o;
    endcase
  end

  assign exp_zero = (exp_res == '0);
  assign mismatch = (result_i != exp_res) || (zero_i != exp_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      vec     <= '0;
      err_cnt <= '0;
      a_o     <= '0;
      b_o     <= '0;
      op_o    <= '0;
    end else begin
      if (clr) begin
        vec     <= '0;
        err_cnt <= '0;
      end
      if (drv) {op_o, a_o, b_o} <= vec;
      if (chk) begin
        if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        // vec parks at max so DONE holds the final vector index
        if (!last_vec) vec <= vec + 1'b1;
      end
    end
  end

`ifdef ALU_BIST_FAIL_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_vld <= 1'b0;
      fail_vec <= '0;
      fail_res <= '0;
    end else if (clr) begin
      fail_vld <= 1'b0;
      fail_vec <= '0;
      fail_res <= '0;
    end else if (chk && mismatch && !fail_vld) begin
      fail_vld <= 1'b1;
      fail_vec <= {op_o, a_o, b_o};
      fail_res <= result_i;
    end
  end
`endif

endmodule

// File: tb/tb_alu_bist_checker.sv
module tb_alu_bist_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  int         fault_mode = 0;

  logic [3:0] a8, b8, res8, a10, b10, res10;
  logic [1:0] op8, op10;
  logic       zero8, zero10;
  logic       busy8, done8, pass8, busy10, done10, pass10;
  logic [7:0] err8;
  logic [9:0] err10;
`ifdef ALU_BIST_FAIL_CAPTURE_EN
  logic       fvld8, fvld10;
  logic [9:0] fvec8, fvec10;
  logic [3:0] fres8, fres10;
`endif

  always #5 clk = ~clk;

  // Behavioural ALU with selectable faults.
  // 0 correct, 1 result[0] stuck at 0, 2 zero inverted for op=10,
  // 3 a=5,b=3,op=00 returns 0.
  function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b,
                                     input logic [1:0] op, input int mode);
    logic [3:0] r;
    logic       z;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    if (mode == 1) r[0] = 1'b0;
    if (mode == 3 && a == 4'h5 && b == 4'h3 && op == 2'b00) r = 4'h0;
    z = (r == 4'h0);
    if (mode == 2 && op == 2'b10) z = ~z;
    return {z, r};
  endfunction

  assign {zero8, res8}   = alu(a8, b8, op8, fault_mode);
  assign {zero10, res10} = alu(a10, b10, op10, fault_mode);

  alu_bist_checker #(.WIDTH(4), .ERR_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a8), .b_o(b8), .op_o(op8),
    .result_i(res8), .zero_i(zero8),
    .busy(busy8), .done(done8), .pass(pass8), .err_cnt(err8)
`ifdef ALU_BIST_FAIL_CAPTURE_EN
    , .fail_vld(fvld8), .fail_vec(fvec8), .fail_res(fres8)
`endif
  );

  alu_bist_checker #(.WIDTH(4), .ERR_W(10)) dut10 (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a10), .b_o(b10), .op_o(op10),
    .result_i(res10), .zero_i(zero10),
    .busy(busy10), .done(done10), .pass(pass10), .err_cnt(err10)
`ifdef ALU_BIST_FAIL_CAPTURE_EN
    , .fail_vld(fvld10), .fail_vec(fvec10), .fail_res(fres10)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         mode;
    int         nerr;     // raw mismatching vector count
    logic       fvld;
    logic [9:0] fvec;
    logic [3:0] fres;
  } vec_t;

  vec_t tbl[5];
  vec_t sb[$];

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Issue start at a negedge, then count cycles until done (bounded).
  // poke_at > 0 re-pulses start at that cycle to show it is ignored when busy.
  task automatic run_sweep(input int poke_at, output int cyc, output int busy_n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_n = 0;
    while (!done8 && cyc < 3000) begin
      if (busy8) busy_n++;
      if (poke_at > 0 && cyc == poke_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    int   cyc, busy_n;
    vec_t e;

    // mode 1: odd results = add 128 + sub 128 + and 64 + or 192 = 512
    tbl[0] = '{1, 512, 1'b1, 10'h001, 4'h0};
    tbl[1] = '{0, 0,   1'b0, 10'h000, 4'h0};
    // mode 2: every op=10 vector (256) has a wrong zero flag
    tbl[2] = '{2, 256, 1'b1, 10'h200, 4'h0};
    tbl[3] = '{3, 1,   1'b1, 10'h053, 4'h0};
    tbl[4] = '{0, 0,   1'b0, 10'h000, 4'h0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_pass", pass8, 0);
    chk("rst_err",  err8, 0);
    chk("rst_ops",  {op8, a8, b8}, 0);
    chk("rst_err10", err10, 0);

    // start and rst in the same cycle: rst wins
    start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    chk("startrst_busy", busy8, 0);
    @(negedge clk);
    chk("startrst_busy2", busy8, 0);

    for (int i = 0; i < 5; i++) begin
      fault_mode = tbl[i].mode;
      sb.push_back(tbl[i]);
      run_sweep(0, cyc, busy_n);
      e = sb.pop_front();
      chk($sformatf("t%0d_done_cycle", i), cyc, 2049);
      chk($sformatf("t%0d_busy_cycles", i), busy_n, 2048);
      chk($sformatf("t%0d_err8", i), err8, sat(e.nerr, 8));
      chk($sformatf("t%0d_err10", i), err10, sat(e.nerr, 10));
      chk($sformatf("t%0d_pass8", i), pass8, (e.nerr == 0));
      chk($sformatf("t%0d_pass10", i), pass10, (e.nerr == 0));
      chk($sformatf("t%0d_last_ops", i), {op8, a8, b8}, 10'h3FF);
`ifdef ALU_BIST_FAIL_CAPTURE_EN
      chk($sformatf("t%0d_fail_vld", i), fvld8, e.fvld);
      if (e.fvld) begin
        chk($sformatf("t%0d_fail_vec", i), fvec8, e.fvec);
        chk($sformatf("t%0d_fail_res", i), fres8, e.fres);
      end
`endif
    end

    // DONE is terminal and status holds without start
    repeat (5) @(negedge clk);
    chk("done_hold", done8, 1);
    chk("done_busy", busy8, 0);

    // start while busy is ignored
    fault_mode = 1;
    run_sweep(1000, cyc, busy_n);
    chk("poke_done_cycle", cyc, 2049);
    chk("poke_err8", err8, 255);

    // rst mid-sweep
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    chk("mid_busy_before", busy8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", busy8, 0);
    chk("mid_err", err8, 0);
    chk("mid_done", done8, 0);
    chk("mid_ops", {op8, a8, b8}, 0);
`ifdef ALU_BIST_FAIL_CAPTURE_EN
    chk("mid_fail_vld", fvld8, 0);
`endif

    fault_mode = 0;
    run_sweep(0, cyc, busy_n);
    chk("post_rst_cycle", cyc, 2049);
    chk("post_rst_pass", pass8, 1);
    chk("post_rst_err", err8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
